inst_mem_responder: RTL
=======================

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 12: instruction address width, matching the 12-bit CPU address output.
REQ-002 Parameter DATA_W, default 18: instruction word width, matching the 18-bit CPU instruction input.
REQ-003 Parameter WAIT_STATES, default 2, legal range 0..15: extra cycles inserted before each ack.
REQ-004 Port clk_i, input, 1: single clock; every flop samples on its rising edge.
REQ-005 Port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 Port clkEn_i, input, 1: clock enable; when low, all state, counters and outputs hold their values.
REQ-007 Port inst_cyc_i, input, 1: bus cycle in progress, driven by the fetch initiator.
REQ-008 Port inst_stb_i, input, 1: fetch request strobe.
REQ-009 Port inst_adr_i, input, ADDR_W: fetch address.
REQ-010 Port inst_dat_o, output, DATA_W: instruction word; valid only while inst_ack_o is high.
REQ-011 Port inst_ack_o, output, 1: fetch acknowledge, exactly one cycle per accepted request.
REQ-012 Port ld_we_i, input, 1: program-load write strobe.
REQ-013 Port ld_adr_i, input, ADDR_W: program-load address.
REQ-014 Port ld_dat_i, input, DATA_W: program-load data.
REQ-015 Port ld_rej_o, output, 1: one-cycle pulse indicating a rejected load write.

Function
REQ-016 The FSM SHALL have three states, with transitions evaluated only when clkEn_i is high:
- IDLE -> WAIT when inst_cyc_i && inst_stb_i; the address is latched on this edge.
- WAIT counts WAIT_STATES cycles, then moves to ACK.
- ACK -> IDLE unconditionally.
REQ-017 With WAIT_STATES=0, the FSM SHALL go IDLE -> ACK directly.
REQ-018 inst_ack_o SHALL be high only in ACK; the fetch-to-ack latency SHALL be WAIT_STATES+1 enabled cycles after the request is sampled in IDLE.
REQ-019 The memory read SHALL be synchronous, using the latched address; inst_dat_o SHALL be 0 whenever inst_ack_o is low.
REQ-020 If inst_stb_i or inst_cyc_i deasserts during WAIT, the FSM SHALL abort to IDLE on the next enabled edge with no ack.
REQ-021 A strobe held high after ACK SHALL start a new transaction from IDLE; back-to-back fetches SHALL ack every WAIT_STATES+2 cycles.
REQ-022 inst_adr_i changes after the latch edge SHALL be ignored for the current transaction.
REQ-023 A load write with ld_we_i && !inst_cyc_i SHALL write ld_dat_i to ld_adr_i on the enabled edge.
REQ-024 ld_we_i && inst_cyc_i SHALL leave the memory unchanged and pulse ld_rej_o for one cycle.
REQ-025 ld_rej_o SHALL reset to 0.
REQ-026 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W, so 0xFFF+1 = 0x000.

Reset
REQ-028 Asserting rst_i SHALL immediately force the following, independent of clk_i and clkEn_i:
- state IDLE, wait counter 0, latched address 0;
- inst_ack_o 0, inst_dat_o 0, ld_rej_o 0;
- prefetch valid flag 0.
REQ-029 Reset asserted mid-transaction SHALL drop the transaction with no ack after release.
REQ-030 Memory contents SHALL NOT be reset.

Configuration
REQ-031 Macro INST_PREFETCH_EN defined: after each ack for address A, the block SHALL read A+1 into a one-entry buffer and set the valid flag.
REQ-032 With INST_PREFETCH_EN defined, a request in IDLE whose address equals the buffered address while the flag is valid SHALL go straight to ACK, giving a latency of 1 cycle.
REQ-033 With INST_PREFETCH_EN defined, any accepted load write and any aborted transaction SHALL clear the valid flag.
REQ-034 Macro INST_PREFETCH_EN undefined: no buffer logic SHALL exist, and every fetch SHALL take WAIT_STATES+1 cycles.

Structure
REQ-035 Package inst_mem_pkg SHALL hold the ADDR_W/DATA_W defaults and the state enum (IDLE, WAIT, ACK).
REQ-036 Storage SHALL be one sub-module, inst_ram: 2^ADDR_W x DATA_W, one synchronous read port and one write port, with read-before-write on collision.

Verification (WAIT_STATES=2 unless stated)
REQ-037 Load 0x005 <- 0x2A5C3 with cyc low, then fetch 0x005 -> ack exactly 3 cycles after the request is sampled, inst_dat_o=0x2A5C3, ack high for 1 cycle.
REQ-038 Strobe high 1 cycle for 0x010, then low -> no ack; FSM back in IDLE; next fetch of 0x010 has full 3-cycle latency.
REQ-039 INST_PREFETCH_EN defined: fetch 0xFFF then 0x000 -> second ack 1 cycle after its request; a load write between the two fetches -> 3 cycles instead.
REQ-040 rst_i pulsed during WAIT -> inst_ack_o and inst_dat_o are 0 immediately; no ack follows after reset release.
REQ-041 ld_we_i with inst_cyc_i high, writing 0x3FFFF to 0x005 -> ld_rej_o pulses once; a later fetch of 0x005 still returns 0x2A5C3.
REQ-042 clkEn_i held low for 4 cycles during WAIT -> ack is delayed by exactly 4 cycles, data unchanged.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared defaults and the fetch FSM state type for the
// instruction memory responder and its storage.
package inst_mem_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 18;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
endpackage

// File: rtl/inst_mem_responder_if.sv
// inst_mem_responder_if: fetch bus (cyc/stb/adr -> dat/ack) and program-load
// port (we/adr/dat -> rej) between a CPU-side initiator and the responder.
//   master : fetch initiator / program loader
//   slave  : inst_mem_responder
interface inst_mem_responder_if import inst_mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              inst_cyc_i;
  logic              inst_stb_i;
  logic [ADDR_W-1:0] inst_adr_i;
  logic [DATA_W-1:0] inst_dat_o;
  logic              inst_ack_o;
  logic              ld_we_i;
  logic [ADDR_W-1:0] ld_adr_i;
  logic [DATA_W-1:0] ld_dat_i;
  logic              ld_rej_o;

  modport master (
    output inst_cyc_i, inst_stb_i, inst_adr_i, ld_we_i, ld_adr_i, ld_dat_i,
    input  inst_dat_o, inst_ack_o, ld_rej_o
  );
  modport slave (
    input  inst_cyc_i, inst_stb_i, inst_adr_i, ld_we_i, ld_adr_i, ld_dat_i,
    output inst_dat_o, inst_ack_o, ld_rej_o
  );
endinterface

// File: rtl/inst_mem_responder_ram.sv
// inst_ram: 2^ADDR_W x DATA_W storage, one write port and one synchronous
// read port. A read and write to the same address on the same edge returns
// the old word (read-before-write). Contents are never reset.
//   clk_i          clock
//   en_i           clock enable for both ports
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i/rdata_o   registered read port
module inst_ram import inst_mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i];
    end
  end
endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: instruction memory slave with programmable wait states.
// A fetch sampled in IDLE latches the address, waits WAIT_STATES cycles, then
// spends one cycle in ACK reading the RAM; ack and data are presented in the
// following cycle, giving a WAIT_STATES+1 cycle fetch-to-ack latency.
// Program-load writes are accepted only while no bus cycle is in progress.
//   clk_i, rst_i (async, active high), clkEn_i (freezes everything when low)
//   bus : inst_mem_responder_if.slave (fetch bus + program-load port)
// Optional build macro INST_PREFETCH_EN: after each ack for A, A+1 is read
// into a one-entry buffer; a fetch hitting it goes straight to ACK.
module inst_mem_responder import inst_mem_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clkEn_i,
  inst_mem_responder_if.slave bus
);
  localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t            state;
  logic [3:0]        wcnt;
  logic [ADDR_W-1:0] adr_q;
  logic              ack_q;
  logic              rej_q;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] dat_sel;
  logic              req;
  logic              ld_acc;
  logic              pf_hit;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;

  assign req    = bus.inst_cyc_i & bus.inst_stb_i;
  assign ld_acc = bus.ld_we_i & ~bus.inst_cyc_i;

  inst_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk_i   (clk_i),
    .en_i    (clkEn_i),
    .we_i    (ld_acc),
    .waddr_i (bus.ld_adr_i),
    .wdata_i (bus.ld_dat_i),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      wcnt  <= '0;
      adr_q <= '0;
      ack_q <= 1'b0;
      rej_q <= 1'b0;
    end else if (clkEn_i) begin
      ack_q <= 1'b0;
      rej_q <= bus.ld_we_i & bus.inst_cyc_i;
      case (state)
        IDLE: if (req) begin
          adr_q <= bus.inst_adr_i;
          wcnt  <= '0;
          state <= (pf_hit || WAIT_STATES == 0) ? ACK : WAIT;
        end
        WAIT: begin
          if (!req)                 state <= IDLE;   // initiator gave up
          else if (wcnt == WS_LAST) state <= ACK;
          else                      wcnt  <= wcnt + 1'b1;
        end
        ACK: begin
          state <= IDLE;
          ack_q <= 1'b1;                             // RAM word lands with it
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INST_PREFETCH_EN
  logic              pf_vld;
  logic              pf_rd;
  logic              use_pf;
  logic              abort;
  logic [ADDR_W-1:0] pf_adr;
  logic [DATA_W-1:0] pf_dat;
  logic [DATA_W-1:0] hit_dat;

  assign abort     = (state == WAIT) && !req;
  assign pf_hit    = pf_vld && (bus.inst_adr_i == pf_adr);
  // The read port is idle during the ack cycle; use it to fetch A+1.
  assign ram_re    = (state == ACK) || ack_q;
  assign ram_raddr = (state == ACK) ? adr_q : adr_q + 1'b1;
  assign dat_sel   = use_pf ? hit_dat : rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pf_vld  <= 1'b0;
      pf_rd   <= 1'b0;
      use_pf  <= 1'b0;
      pf_adr  <= '0;
      pf_dat  <= '0;
      hit_dat <= '0;
    end else if (clkEn_i) begin
      // A load in the same cycle as the prefetch read could make it stale.
      pf_rd <= ack_q && !ld_acc;
      if (ack_q) pf_adr <= adr_q + 1'b1;
      if (pf_rd) pf_dat <= rdata;
      if (pf_rd && !ld_acc) pf_vld <= 1'b1;
      if (ack_q || ld_acc || abort) pf_vld <= 1'b0;
      // Snapshot the buffer on a hit; it may be refilled before the ack.
      if (state == IDLE && req) begin
        use_pf  <= pf_hit;
        hit_dat <= pf_dat;
      end
    end
  end
`else
  assign pf_hit    = 1'b0;
  assign ram_re    = (state == ACK);
  assign ram_raddr = adr_q;
  assign dat_sel   = rdata;
`endif

  assign bus.inst_ack_o = ack_q;
  assign bus.inst_dat_o = ack_q ? dat_sel : '0;
  assign bus.ld_rej_o   = rej_q;
endmodule
